// File: rtl/log2_frac_sq_if.sv
// Handshake bundle for the log2 fractional-bit extractor: operand in, {int,frac} result out.
// The slave modport is the extractor side; master is the upstream/downstream side.
`timescale 1ns/1ps
interface log2_frac_sq_if #(
    parameter int W  = 42,
    parameter int IW = 6,
    parameter int FB = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_mant;
    logic [IW-1:0]     in_int;
    logic              out_valid;
    logic              out_ready;
    logic [IW+FB-1:0]  out_log;
    logic              out_err;

    modport master (
        output in_valid, in_mant, in_int, out_ready,
        input  in_ready, out_valid, out_log, out_err
    );

    modport slave (
        input  in_valid, in_mant, in_int, out_ready,
        output in_ready, out_valid, out_log, out_err
    );
endinterface

// File: rtl/log2_frac_sq.sv
// Iterative log2 fraction extractor: squares a [1,2) mantissa once per clock, one fraction bit per step.
// Optional build macro LOG2_FRAC_ROUND_EN rounds each squaring to nearest instead of truncating.
`timescale 1ns/1ps
module log2_frac_sq #(
    parameter int W  = 42,
    parameter int IW = 6,
    parameter int FB = 16
) (
    input  logic          clk,
    input  logic          rst,
    log2_frac_sq_if.slave bus
);
    localparam int CW = (FB > 1) ? $clog2(FB) : 1;
    localparam int LW = IW + FB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [W-1:0]    m;
    logic [W-1:0]    m_next;
    logic [IW-1:0]   int_r;
    logic [FB-1:0]   frac;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  sq;
    logic            sq_bit;

    logic            accept;
    logic            last_step;
    logic [LW-1:0]   done_log;
    logic            done_err;

    logic            in_ready_q;
    logic            out_valid_q;
    logic [LW-1:0]   out_log_q;
    logic            out_err_q;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_step = (count == CW'(FB - 1));

    always_comb begin
        sq = {{W{1'b0}}, m} * {{W{1'b0}}, m};
    end

    // sq is Q2.(2W-2); its MSB says whether m^2 landed in [2,4), which is the next log2 bit.
`ifdef LOG2_FRAC_ROUND_EN
    logic [W:0] win_r;

    always_comb begin
        sq_bit = sq[2*W-1];
        if (sq_bit) begin
            win_r = {1'b0, sq[2*W-1:W]} + {{W{1'b0}}, sq[W-1]};
        end else begin
            win_r = {1'b0, sq[2*W-2:W-1]} + {{W{1'b0}}, sq[W-2]};
        end
        m_next = win_r[W] ? {W{1'b1}} : win_r[W-1:0];
    end
`else
    always_comb begin
        sq_bit = sq[2*W-1];
        m_next = sq_bit ? sq[2*W-1:W] : sq[2*W-2:W-1];
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)        next_state = bus.in_mant[W-1] ? RUN : DONE;
            RUN:  if (last_step)     next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Result captured on entry to DONE: error operands skip RUN and report a zero fraction.
    always_comb begin
        done_err = (state == IDLE);
        if (state == IDLE) begin
            done_log = {bus.in_int, {FB{1'b0}}};
        end else begin
            done_log = {int_r, frac[FB-2:0], sq_bit};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m     <= '0;
            int_r <= '0;
            frac  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m     <= bus.in_mant;
                        int_r <= bus.in_int;
                        frac  <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    m     <= m_next;
                    frac  <= {frac[FB-2:0], sq_bit};
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are registered decodes of the next state: out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_log_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            in_ready_q  <= (next_state == IDLE);
            out_valid_q <= (next_state == DONE);
            if ((next_state == DONE) && (state != DONE)) begin
                out_log_q <= done_log;
                out_err_q <= done_err;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_log   = out_log_q;
    assign bus.out_err   = out_err_q;

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_log_q) && $stable(out_err_q)));

    a_one_side: assert property (@(posedge clk) disable iff (rst)
        !(in_ready_q && out_valid_q));

    a_valid_decode: assert property (@(posedge clk) disable iff (rst)
        out_valid_q == (state == DONE));
`endif
endmodule

// File: tb/tb_log2_frac_sq.sv
// Self-checking bench for log2_frac_sq: vector table, corner sequences and random ops against a scoreboard.
`timescale 1ns/1ps
module tb_log2_frac_sq;
    localparam int W  = 42;
    localparam int IW = 6;
    localparam int FB = 16;
    localparam int LW = IW + FB;

    typedef struct {
        logic [W-1:0]  mant;
        logic [IW-1:0] ival;
        logic [LW-1:0] exp_log;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [LW-1:0] exp_log;
        logic          exp_err;
        int            exp_lat;
        int            acc_cyc;
        logic [W-1:0]  mant;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    item_t sb[$];
    bit    ready_rand = 1'b0;
    logic  ready_fixed = 1'b1;

    log2_frac_sq_if #(.W(W), .IW(IW), .FB(FB)) bus();

    log2_frac_sq #(.W(W), .IW(IW), .FB(FB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-accurate reference of the squaring algorithm, in truncating or rounding form.
    function automatic logic [LW-1:0] model(input logic [W-1:0] mant, input logic [IW-1:0] ival);
        logic [W-1:0]   mm;
        logic [2*W-1:0] s;
        logic [FB-1:0]  f;
        logic [W:0]     t;
        logic           b;
        if (!mant[W-1]) return {ival, {FB{1'b0}}};
        mm = mant;
        f  = '0;
        for (int k = 0; k < FB; k++) begin
            s = {{W{1'b0}}, mm} * {{W{1'b0}}, mm};
            b = s[2*W-1];
`ifdef LOG2_FRAC_ROUND_EN
            if (b) t = {1'b0, s[2*W-1:W]} + {{W{1'b0}}, s[W-1]};
            else   t = {1'b0, s[2*W-2:W-1]} + {{W{1'b0}}, s[W-2]};
            mm = t[W] ? {W{1'b1}} : t[W-1:0];
`else
            mm = b ? s[2*W-1:W] : s[2*W-2:W-1];
`endif
            f = {f[FB-2:0], b};
        end
        return {ival, f};
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Output monitor: latency, hold stability, result and error-bound checks on each handshake.
    logic          seen_valid = 1'b0;
    logic          stalled = 1'b0;
    int            first_cyc = 0;
    logic [LW-1:0] held_log;
    logic          held_err;
    item_t         mon_it;
    real           tv, rv, dv;

    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
            stalled    = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                first_cyc  = cyc;
            end
            if (stalled) begin
                check("hold_log", 64'(bus.out_log), 64'(held_log));
                check("hold_err", 64'(bus.out_err), 64'(held_err));
            end
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got log %h with no operand outstanding", bus.out_log);
                end else begin
                    mon_it = sb.pop_front();
                    check("out_log", 64'(bus.out_log), 64'(mon_it.exp_log));
                    check("out_err", 64'(bus.out_err), 64'(mon_it.exp_err));
                    check("latency", 64'(first_cyc - mon_it.acc_cyc), 64'(mon_it.exp_lat));
                    if (!mon_it.exp_err) begin
                        tv = $ln(real'(mon_it.mant) / (2.0 ** (W - 1))) / $ln(2.0)
                             + real'(mon_it.exp_log[LW-1:FB]);
                        rv = real'(bus.out_log) / (2.0 ** FB);
                        dv = (tv > rv) ? (tv - rv) : (rv - tv);
                        check("log2_error_bound", 64'(dv < (2.0 ** (-FB) + 2.0 ** (-FB - 2))), 64'd1);
                    end
                end
                seen_valid = 1'b0;
                stalled    = 1'b0;
            end else begin
                stalled  = 1'b1;
                held_log = bus.out_log;
                held_err = bus.out_err;
            end
        end
    end

    task automatic send(input logic [W-1:0] mant, input logic [IW-1:0] ival,
                        input logic [LW-1:0] exp_log, input logic exp_err, output int acc);
        item_t it;
        int    n;
        bit    timed_out;
        n = 0;
        timed_out = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_mant  = mant;
        bus.in_int   = ival;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        acc = cyc;
        if (timed_out) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            it.exp_log = exp_log;
            it.exp_err = exp_err;
            it.exp_lat = exp_err ? 1 : FB + 1;
            it.acc_cyc = cyc;
            it.mant    = mant;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb.size(), limit);
            sb.delete();
        end
    endtask

    initial begin
        vec_t         tbl[7];
        int           acc0, acc1, n;
        bit           ok;
        logic [63:0]  r;
        logic [W-1:0] mant;
        logic [IW-1:0] iv;

        bus.in_valid = 1'b0;
        bus.in_mant  = '0;
        bus.in_int   = '0;

        tbl[0] = '{42'h200_0000_0000, 6'd5,  {6'd5, 16'h0000},  1'b0};
        tbl[1] = '{42'h300_0000_0000, 6'd0,  22'h0095C0,        1'b0};
        tbl[2] = '{42'h100_0000_0000, 6'd3,  {6'd3, 16'h0000},  1'b1};
        tbl[3] = '{42'h3FF_FFFF_FFFF, 6'd10, model(42'h3FF_FFFF_FFFF, 6'd10), 1'b0};
        tbl[4] = '{42'h2D4_13CC_CFE7, 6'd1,  model(42'h2D4_13CC_CFE7, 6'd1),  1'b0};
        tbl[5] = '{42'h300_0000_0000, 6'd63, {6'd63, 16'h95C0}, 1'b0};
        tbl[6] = '{42'h000_0000_0000, 6'd63, {6'd63, 16'h0000}, 1'b1};

        // Reset state, then in_ready rising one cycle after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_log",   64'(bus.out_log),   64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        ready_fixed = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].mant, tbl[i].ival, tbl[i].exp_log, tbl[i].exp_err, acc0);
            drain(100);
        end

        // Back-to-back operands with out_ready high.
        send(42'h300_0000_0000, 6'd2, {6'd2, 16'h95C0}, 1'b0, acc0);
        send(42'h300_0000_0000, 6'd4, {6'd4, 16'h95C0}, 1'b0, acc1);
        check("throughput", 64'(acc1 - acc0), 64'(FB + 2));
        drain(100);

        // Downstream stall: result held, nothing accepted, resume one cycle after the handshake.
        ready_fixed = 1'b0;
        send(42'h300_0000_0000, 6'd7, {6'd7, 16'h95C0}, 1'b0, acc0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 64'(bus.out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready",  64'(bus.in_ready),  64'd0);
        end
        ready_fixed = 1'b1;
        @(negedge clk);
        check("handshake_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("resume_in_ready",  64'(bus.in_ready),  64'd1);
        check("resume_out_valid", 64'(bus.out_valid), 64'd0);
        drain(20);

        // Reset in the middle of RUN abandons the operand.
        send(42'h2AB_CDEF_0123, 6'd9, model(42'h2AB_CDEF_0123, 6'd9), 1'b0, acc0);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ok = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b0;
        end
        check("no_valid_after_mid_rst", 64'(ok), 64'd1);
        send(42'h300_0000_0000, 6'd0, 22'h0095C0, 1'b0, acc0);
        drain(100);

        // Random normalized operands with random backpressure.
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r    = {$urandom, $urandom};
            mant = {1'b1, r[W-2:0]};
            iv   = IW'($urandom_range(0, (1 << IW) - 1));
            send(mant, iv, model(mant, iv), 1'b0, acc0);
        end
        drain(200);
        ready_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/log2_frac_sq.md
# log2_frac_sq

Iterative fractional-bit extractor for the log2 datapath. Sits directly downstream of the normalization stage: it accepts a mantissa normalized to [1,2) plus the integer exponent found during normalization, and produces the fixed-point result {integer, fraction} by repeated squaring, one fraction bit per clock. Valid/ready handshakes on both sides; one operation in flight at a time.

## Interface
Parameters:
- W, 42, mantissa width, unsigned Q1.(W-1); MSB weight 1.0
- IW, 6, integer-part width
- FB, 16, number of fraction bits produced

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream has a normalized operand
- in_ready  out  1  block can accept an operand
- in_mant  in  W  normalized mantissa, Q1.(W-1)
- in_int  in  IW  integer part of log2, passed through
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_log  out  IW+FB  {int, frac}, unsigned Q(IW).(FB)
- out_err  out  1  operand was not normalized (in_mant[W-1]==0)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch m<=in_mant, int_r<=in_int, count<=0, frac<=0, err<=~in_mant[W-1]; go to RUN.
- RUN, per cycle: sq = m*m (2W bits, Q2.(2W-2)). If sq[2W-1]: bit=1, m<=sq[2W-1:W]; else bit=0, m<=sq[2W-2:W-1]. frac<={frac[FB-2:0],bit}. count<=count+1. When count==FB-1 go to DONE.
- If err latched: RUN is skipped; go straight to DONE with frac=0.
- DONE: out_valid=1, out_log={int_r,frac}, out_err=err. On out_ready: go to IDLE.
- out_log/out_err held stable while out_valid && !out_ready.
- No new operand accepted in RUN or DONE (in_ready=0).
- Truncation only (default build); result is floor-biased, never exceeds the true value.

## Timing
- Reset values: in_ready=0 during the rst cycle, 1 from the first cycle after rst deasserts; out_valid=0, out_log=0, out_err=0; FSM=IDLE.
- Latency: accept at cycle 0, out_valid rises at cycle FB+1 (17 by default); error operand: cycle 1.
- Throughput: one result per FB+2 cycles with out_ready tied high (DONE→IDLE→accept).
- in_ready is a registered state decode; no combinational path from out_ready to in_ready.
- rst mid-RUN or mid-DONE: abandons the operation immediately; no out_valid for it.
- out_ready asserted while out_valid=0: ignored.

## Configuration
- LOG2_FRAC_ROUND_EN defined: each squaring step rounds to nearest before truncation by adding 1 at bit W-1 (bit=1 branch) or bit W-2 (bit=0 branch) of sq; if the addition would overflow the selected W-bit window, m saturates to all-ones. Latency unchanged.
- Undefined: plain truncation as above.

## Test plan
- in_mant=42'h200_0000_0000 (1.0), in_int=5, out_ready=1 -> out_valid at cycle 17, out_log={6'd5,16'h0000}, out_err=0.
- in_mant=42'h300_0000_0000 (1.5), in_int=0 -> out_log=22'h0095C0, out_err=0; matches bit-accurate model.
- in_mant=42'h100_0000_0000 (MSB clear), in_int=3 -> out_valid at cycle 1, out_err=1, out_log={6'd3,16'h0000}.
- out_ready held low 10 cycles after out_valid -> out_log/out_err stable, in_ready=0 throughout; accept resumes the cycle after out_ready handshake + 1.
- rst asserted at RUN cycle 8 -> out_valid never rises for that operand; next operand (1.5) yields 22'h0095C0.
- Random normalized mantissas, 1000 ops, random out_ready -> every result equals bit-accurate model (truncating or rounding per LOG2_FRAC_ROUND_EN); |error vs. real log2| < 2^-FB+2^-(FB+2).
